// File: rtl/step_accumulator_pkg.sv
// Shared types for the step accumulator bank: command opcodes, FSM states and
// the channel-index width helper used by both the interface and the top.
package step_accumulator_pkg;

  typedef enum logic [1:0] {
    OP_ADD       = 2'd0,
    OP_SUB       = 2'd1,
    OP_LOAD      = 2'd2,
    OP_CLEAR_ALL = 2'd3
  } cmd_op_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_e;

  // Channel index width; never zero so a single-channel bank still has a chan field.
  function automatic int unsigned cidx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/step_accumulator_bank_if.sv
// Single-beat command channel (valid/ready) into the accumulator bank.
interface step_accumulator_bank_if
  import step_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned CIDX = cidx_width(CHANNELS);

  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [CIDX-1:0] cmd_chan;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_chan,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_chan,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/step_accumulator_bank_sat_addsub.sv
// Combinational WIDTH-bit add/subtract with optional clamping. The flag is the
// carry (add) or borrow (sub) out of a WIDTH+1-bit operation.
module sat_addsub #(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             flag
);

  logic [WIDTH:0] ext;

  // Extended arithmetic, then wrap or clamp depending on SATURATE.
  always_comb begin
    ext    = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    flag   = ext[WIDTH];
    result = ext[WIDTH-1:0];
    if (SATURATE && flag) begin
      result = sub ? '0 : '1;
    end
  end

endmodule

// File: rtl/step_accumulator_bank.sv
// Bank of CHANNELS accumulators: per-channel STEP ticks, single-beat
// ADD/SUB/LOAD commands and a one-channel-per-cycle CLEAR_ALL sweep.
module step_accumulator_bank
  import step_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned STEP     = 3,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       tick_en,
  step_accumulator_bank_if.slave    cmd,
  output logic [CHANNELS*WIDTH-1:0] acc_out,
  output logic [CHANNELS-1:0]       ovf_out,
  output logic                      busy
);

  localparam int unsigned    CIDX    = cidx_width(CHANNELS);
  localparam logic [WIDTH-1:0] StepVal = WIDTH'(STEP);

  state_e            state_q, state_d;
  logic [CIDX-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  acc_q [CHANNELS];
  logic [WIDTH-1:0]  acc_d [CHANNELS];
  logic [CHANNELS-1:0] ovf_q, ovf_d;

  logic [WIDTH-1:0]    tick_res [CHANNELS];
  logic [CHANNELS-1:0] tick_flag;

  logic [WIDTH-1:0]    cmd_a, cmd_res;
  logic                cmd_flag, cmd_sub, accept;
  logic [CHANNELS-1:0] chan_hit;
  cmd_op_e             op;

  // One tick adder per channel so every channel can step in the same cycle.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_tick
    sat_addsub #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_tick (
      .a      (acc_q[g]),
      .b      (StepVal),
      .sub    (1'b0),
      .result (tick_res[g]),
      .flag   (tick_flag[g])
    );
  end

  // Shared command-path adder operating on the addressed channel.
  sat_addsub #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_cmd (
    .a      (cmd_a),
    .b      (cmd.cmd_data),
    .sub    (cmd_sub),
    .result (cmd_res),
    .flag   (cmd_flag)
  );

  // Decode the target channel; out-of-range indices hit nothing and are ignored.
  always_comb begin
    chan_hit = '0;
    cmd_a    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cmd.cmd_chan == CIDX'(i)) begin
        chan_hit[i] = 1'b1;
        cmd_a       = acc_q[i];
      end
    end
  end

  assign op      = cmd_op_e'(cmd.cmd_op);
  assign cmd_sub = (op == OP_SUB);
  assign accept  = cmd.cmd_valid && (state_q == S_IDLE);

  // Next-state logic: ticks first, then an accepted command overrides its channel.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    ovf_d         = ovf_q;
    cmd.cmd_ready = 1'b0;
    busy          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd.cmd_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
          if (tick_en[i]) begin
            acc_d[i] = tick_res[i];
            ovf_d[i] = ovf_q[i] | tick_flag[i];
          end
        end
        if (accept) begin
          unique case (op)
            OP_ADD, OP_SUB: begin
              for (int i = 0; i < CHANNELS; i++) begin
                if (chan_hit[i]) begin
                  acc_d[i] = cmd_res;
                  ovf_d[i] = ovf_q[i] | cmd_flag;
                end
              end
            end
            OP_LOAD: begin
              for (int i = 0; i < CHANNELS; i++) begin
                if (chan_hit[i]) begin
                  acc_d[i] = cmd.cmd_data;
                  ovf_d[i] = 1'b0;
                end
              end
            end
            OP_CLEAR_ALL: begin
              state_d = S_SWEEP;
              idx_d   = '0;
            end
            default: ;
          endcase
        end
      end
      S_SWEEP: begin
        busy = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
          if (idx_q == CIDX'(i)) begin
            acc_d[i] = '0;
            ovf_d[i] = 1'b0;
          end
        end
        if (idx_q == CIDX'(CHANNELS - 1)) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ovf_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      acc_q   <= acc_d;
    end
  end

  // Flatten the accumulator array onto the output bus.
  always_comb begin
    acc_out = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      acc_out[i*WIDTH +: WIDTH] = acc_q[i];
    end
  end

  assign ovf_out = ovf_q;

endmodule

// File: tb/tb_step_accumulator_bank.sv
// Bench for step_accumulator_bank: three instances (wrap, saturate, and a
// 1-channel 4-bit STEP=15 bank) checked every cycle against an integer model.
module tb_step_accumulator_bank;
  import step_accumulator_pkg::*;

  localparam int NI = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Per-instance stimulus; instances 0 and 1 always carry identical stimulus.
  logic [3:0] v_tick  [NI];
  logic       v_valid [NI];
  logic [1:0] v_op    [NI];
  logic [1:0] v_chan  [NI];
  logic [7:0] v_data  [NI];
  bit         accepted [NI];

  // Reference model state.
  int m_acc [NI][4];
  bit m_ovf [NI][4];
  bit m_sweep [NI];
  int m_idx [NI];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] acc0, acc1;
  logic [3:0]  ovf0, ovf1;
  logic [3:0]  acc2;
  logic [0:0]  ovf2;
  logic        busy0, busy1, busy2;

  step_accumulator_bank_if #(.WIDTH(8), .CHANNELS(4)) if0 ();
  step_accumulator_bank_if #(.WIDTH(8), .CHANNELS(4)) if1 ();
  step_accumulator_bank_if #(.WIDTH(4), .CHANNELS(1)) if2 ();

  assign if0.cmd_valid = v_valid[0];
  assign if0.cmd_op    = v_op[0];
  assign if0.cmd_chan  = v_chan[0];
  assign if0.cmd_data  = v_data[0];
  assign if1.cmd_valid = v_valid[1];
  assign if1.cmd_op    = v_op[1];
  assign if1.cmd_chan  = v_chan[1];
  assign if1.cmd_data  = v_data[1];
  assign if2.cmd_valid = v_valid[2];
  assign if2.cmd_op    = v_op[2];
  assign if2.cmd_chan  = v_chan[2][0:0];
  assign if2.cmd_data  = v_data[2][3:0];

  step_accumulator_bank #(.WIDTH(8), .CHANNELS(4), .STEP(3), .SATURATE(1'b0)) u_dut0 (
    .clock (clock), .reset (reset), .tick_en (v_tick[0]), .cmd (if0),
    .acc_out (acc0), .ovf_out (ovf0), .busy (busy0)
  );
  step_accumulator_bank #(.WIDTH(8), .CHANNELS(4), .STEP(3), .SATURATE(1'b1)) u_dut1 (
    .clock (clock), .reset (reset), .tick_en (v_tick[1]), .cmd (if1),
    .acc_out (acc1), .ovf_out (ovf1), .busy (busy1)
  );
  step_accumulator_bank #(.WIDTH(4), .CHANNELS(1), .STEP(15), .SATURATE(1'b0)) u_dut2 (
    .clock (clock), .reset (reset), .tick_en (v_tick[2][0:0]), .cmd (if2),
    .acc_out (acc2), .ovf_out (ovf2), .busy (busy2)
  );

  function automatic int p_w(int k);   return (k == 2) ? 4 : 8;  endfunction
  function automatic int p_n(int k);   return (k == 2) ? 1 : 4;  endfunction
  function automatic int p_s(int k);   return (k == 2) ? 15 : 3; endfunction
  function automatic bit p_sat(int k); return (k == 1);          endfunction

  function automatic int get_acc(int k, int i);
    case (k)
      0:       return int'(acc0[i*8 +: 8]);
      1:       return int'(acc1[i*8 +: 8]);
      default: return int'(acc2);
    endcase
  endfunction

  function automatic int get_ovf(int k, int i);
    case (k)
      0:       return int'(ovf0[i]);
      1:       return int'(ovf1[i]);
      default: return int'(ovf2[0]);
    endcase
  endfunction

  function automatic int get_busy(int k);
    case (k)
      0:       return int'(busy0);
      1:       return int'(busy1);
      default: return int'(busy2);
    endcase
  endfunction

  function automatic int get_ready(int k);
    case (k)
      0:       return int'(if0.cmd_ready);
      1:       return int'(if1.cmd_ready);
      default: return int'(if2.cmd_ready);
    endcase
  endfunction

  task automatic check_val(string tag, int got, int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // acc +/- b computed as a plain integer, then wrapped or clamped to the range.
  function automatic void model_arith(int k, int i, int b, bit sub);
    int mx = 1 << p_w(k);
    int v  = sub ? (m_acc[k][i] - b) : (m_acc[k][i] + b);
    if (v < 0 || v >= mx) begin
      m_ovf[k][i] = 1'b1;
      if (p_sat(k)) v = (v < 0) ? 0 : mx - 1;
      else          v = (v < 0) ? v + mx : v - mx;
    end
    m_acc[k][i] = v;
  endfunction

  function automatic void model_update(int k);
    int  n    = p_n(k);
    int  c    = int'(v_chan[k]);
    int  d    = int'(v_data[k]) & ((1 << p_w(k)) - 1);
    bit  acc  = v_valid[k] && !m_sweep[k];
    bit  targ = acc && (v_op[k] != 2'd3) && (c < n);
    if (m_sweep[k]) begin
      m_acc[k][m_idx[k]] = 0;
      m_ovf[k][m_idx[k]] = 1'b0;
      if (m_idx[k] == n - 1) begin
        m_sweep[k] = 1'b0;
        m_idx[k]   = 0;
      end else begin
        m_idx[k]++;
      end
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (v_tick[k][i] && !(targ && c == i)) model_arith(k, i, p_s(k), 1'b0);
    end
    if (acc) begin
      case (v_op[k])
        2'd0: if (c < n) model_arith(k, c, d, 1'b0);
        2'd1: if (c < n) model_arith(k, c, d, 1'b1);
        2'd2: if (c < n) begin m_acc[k][c] = d; m_ovf[k][c] = 1'b0; end
        default: begin m_sweep[k] = 1'b1; m_idx[k] = 0; end
      endcase
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NI; k++) begin
      m_sweep[k] = 1'b0;
      m_idx[k]   = 0;
      for (int i = 0; i < 4; i++) begin
        m_acc[k][i] = 0;
        m_ovf[k][i] = 1'b0;
      end
    end
  endfunction

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < p_n(k); i++) begin
        check_val($sformatf("k%0d acc%0d", k, i), get_acc(k, i), m_acc[k][i]);
        check_val($sformatf("k%0d ovf%0d", k, i), get_ovf(k, i), int'(m_ovf[k][i]));
      end
      check_val($sformatf("k%0d busy", k), get_busy(k), int'(m_sweep[k]));
      check_val($sformatf("k%0d ready", k), get_ready(k), int'(!m_sweep[k]));
    end
  endtask

  // Advance one clock edge with the current inputs, then compare everything.
  task automatic step_cycle();
    bit acc_now [NI];
    for (int k = 0; k < NI; k++) acc_now[k] = v_valid[k] && !m_sweep[k];
    @(posedge clock);
    #1;
    for (int k = 0; k < NI; k++) begin
      model_update(k);
      accepted[k] = acc_now[k];
    end
    check_all();
  endtask

  task automatic set_cmd(bit valid, logic [1:0] op, logic [1:0] chan, logic [7:0] data,
                         logic [3:0] tick);
    for (int k = 0; k < 2; k++) begin
      v_valid[k] = valid;
      v_op[k]    = op;
      v_chan[k]  = chan;
      v_data[k]  = data;
      v_tick[k]  = tick;
    end
  endtask

  function automatic logic [7:0] pick_data(int mx);
    case ($urandom_range(0, 4))
      0:       return 8'd0;
      1:       return 8'd1;
      2:       return 8'(mx);
      3:       return 8'(mx - 1);
      default: return 8'($urandom_range(0, mx));
    endcase
  endfunction

  // New random command unless an unaccepted one must still be held.
  task automatic drive_random();
    int r;
    if (!(v_valid[0] && !accepted[0])) begin
      r          = $urandom_range(0, 15);
      v_valid[0] = ($urandom_range(0, 2) == 0);
      v_op[0]    = (r == 0) ? 2'd3 : 2'(r % 3);
      v_chan[0]  = 2'($urandom_range(0, 3));
      v_data[0]  = pick_data(255);
    end
    v_tick[0] = 4'($urandom);
    set_cmd(v_valid[0], v_op[0], v_chan[0], v_data[0], v_tick[0]);
    if (!(v_valid[2] && !accepted[2])) begin
      r          = $urandom_range(0, 15);
      v_valid[2] = ($urandom_range(0, 2) == 0);
      v_op[2]    = (r == 0) ? 2'd3 : 2'(r % 3);
      v_chan[2]  = 2'($urandom_range(0, 1));
      v_data[2]  = pick_data(15);
    end
    v_tick[2] = 4'($urandom_range(0, 1));
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      v_tick[k] = '0; v_valid[k] = 1'b0; v_op[k] = '0; v_chan[k] = '0; v_data[k] = '0;
      accepted[k] = 1'b0;
    end
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clock);
    reset = 1'b0;

    // Free-running ticks on ch0; the 1-channel bank steps by 15 (i.e. -1 mod 16).
    set_cmd(1'b0, 2'd0, 2'd0, 8'd0, 4'b0001);
    v_tick[2] = 4'b0001;
    for (int c = 1; c <= 5; c++) begin
      step_cycle();
      check_val("t1 acc0", int'(acc0[7:0]), 3 * c);
      check_val("t6 acc", int'(acc2), 16 - c);
      check_val("t6 ovf", int'(ovf2[0]), (c >= 2) ? 1 : 0);
    end
    check_val("t1 others", int'(acc0[31:8]), 0);

    // Asynchronous reset takes effect before the next edge.
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_val("rst acc", int'(acc0), 0);
    check_val("rst acc2", int'(acc2), 0);
    check_val("rst ovf", int'(ovf2[0]), 0);
    check_all();
    @(negedge clock);
    reset = 1'b0;
    v_tick[2] = '0;

    // LOAD 254 then one tick; instance 2 gets an out-of-range LOAD.
    set_cmd(1'b1, 2'd2, 2'd1, 8'd254, 4'b0000);
    v_valid[2] = 1'b1; v_op[2] = 2'd2; v_chan[2] = 2'd1; v_data[2] = 8'd5;
    step_cycle();
    v_valid[2] = 1'b0;
    check_val("t6 ignored", int'(acc2), 0);
    set_cmd(1'b0, 2'd0, 2'd0, 8'd0, 4'b0010);
    step_cycle();
    check_val("t2 wrap acc1", int'(acc0[15:8]), 1);
    check_val("t2 wrap ovf1", int'(ovf0[1]), 1);
    check_val("t2 sat acc1", int'(acc1[15:8]), 255);
    check_val("t2 sat ovf1", int'(ovf1[1]), 1);

    // SUB from zero, then LOAD clears the sticky flag.
    set_cmd(1'b1, 2'd1, 2'd2, 8'd5, 4'b0000);
    step_cycle();
    check_val("t3 wrap acc2", int'(acc0[23:16]), 251);
    check_val("t3 wrap ovf2", int'(ovf0[2]), 1);
    check_val("t3 sat acc2", int'(acc1[23:16]), 0);
    check_val("t3 sat ovf2", int'(ovf1[2]), 1);
    set_cmd(1'b1, 2'd2, 2'd2, 8'd7, 4'b0000);
    step_cycle();
    check_val("t3 load ovf", int'(ovf0[2]), 0);
    check_val("t3 load ovf sat", int'(ovf1[2]), 0);

    // Command beats a same-channel tick; other channels still tick.
    set_cmd(1'b1, 2'd2, 2'd0, 8'd20, 4'b0000);
    step_cycle();
    set_cmd(1'b1, 2'd0, 2'd0, 8'd10, 4'b1001);
    step_cycle();
    check_val("t4 acc0", int'(acc0[7:0]), 30);
    check_val("t4 acc3", int'(acc0[31:24]), 3);

    // CLEAR_ALL sweep with a held ADD behind it.
    set_cmd(1'b1, 2'd3, 2'd0, 8'd0, 4'b1111);
    step_cycle();
    check_val("t5 busy0", int'(busy0), 1);
    check_val("t5 acc0 kept", int'(acc0[7:0]), 33);
    set_cmd(1'b1, 2'd0, 2'd1, 8'd5, 4'b1111);
    for (int s = 0; s < 4; s++) begin
      step_cycle();
      check_val("t5 cleared", int'(acc0[s*8 +: 8]), 0);
      check_val("t5 busy", int'(busy0), (s < 3) ? 1 : 0);
      check_val("t5 ready", int'(if0.cmd_ready), (s < 3) ? 0 : 1);
      if (s < 3) check_val("t5 frozen", int'(acc0[31:24]), 6);
    end
    step_cycle();
    check_val("t5 held add", int'(acc0[15:8]), 5);
    check_val("t5 tick resumes", int'(acc0[7:0]), 3);
    set_cmd(1'b0, 2'd0, 2'd0, 8'd0, 4'b0000);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      drive_random();
      step_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/step_accumulator_bank.md
Name: step_accumulator_bank

Overview:
- Bank of CHANNELS independent WIDTH-bit accumulators.
- Each channel can free-run, adding the constant STEP every enabled cycle (the tick path).
- Each channel can also be modified by single-beat commands over a valid/ready interface.
- A multi-cycle CLEAR_ALL sweep is driven by a small FSM.
- Sits beside control logic as a generic counter/credit/timestamp bank; generalises a fixed "reg += 3" tick task to N channels with configurable width, step, saturation and commands.

Parameters:
- WIDTH, 8, accumulator width in bits (>=2).
- CHANNELS, 4, number of accumulators (>=1).
- STEP, 3, constant added on each tick; must fit in WIDTH bits.
- SATURATE, 0, 0 = modular wrap; 1 = clamp at 0 / 2^WIDTH-1.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- tick_en  in  CHANNELS  per-channel enable for the STEP increment.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&&ready.
- cmd_op  in  2  0=ADD, 1=SUB, 2=LOAD, 3=CLEAR_ALL.
- cmd_chan  in  CIDX  target channel; CIDX = max(1,$clog2(CHANNELS)).
- cmd_data  in  WIDTH  operand for ADD/SUB/LOAD.
- acc_out  out  CHANNELS*WIDTH  flattened accumulator values; channel i at [i*WIDTH +: WIDTH].
- ovf_out  out  CHANNELS  sticky overflow/underflow flags.
- busy  out  1  high while the CLEAR_ALL sweep is in progress.

Behaviour:
- Reset (asynchronous, immediate): all acc = 0, all ovf = 0, state = IDLE, sweep index = 0, busy = 0, cmd_ready = 1.
- Outputs are registered state; acc_out and ovf_out reflect an update one cycle after the causing edge inputs. Latency is 1 cycle for every accepted operation and every tick.
- FSM states:
  - IDLE: cmd_ready = 1, busy = 0.
  - SWEEP: cmd_ready = 0, busy = 1.
- Tick path (IDLE only): for each i with tick_en[i]=1, acc[i] <= acc[i] + STEP.
  - Carry out with SATURATE=0: wrap, set ovf[i].
  - Carry out with SATURATE=1: clamp to all-ones, set ovf[i].
- Commands (accepted in IDLE on cmd_valid):
  - ADD: acc[c] + cmd_data; overflow rules as for the tick path.
  - SUB: acc[c] - cmd_data. Borrow with SATURATE=0 wraps and sets ovf[c]; with SATURATE=1 clamps to 0 and sets ovf[c].
  - LOAD: acc[c] <= cmd_data and ovf[c] <= 0.
  - CLEAR_ALL: go to SWEEP with index 0; acc[0] is not cleared in the accept cycle.
- Command and tick on the same channel in the same cycle: the command wins and the tick is dropped for that channel that cycle. Other channels still tick.
- cmd_chan >= CHANNELS: command is accepted and ignored (no state change). Ticks proceed normally.
- SWEEP:
  - Each cycle clears acc[idx]=0 and ovf[idx]=0, then idx++.
  - After clearing idx=CHANNELS-1, return to IDLE on the next edge.
  - The sweep takes exactly CHANNELS cycles after acceptance.
  - All ticks are suppressed on all channels during SWEEP.
  - cmd_valid is held off by cmd_ready=0; the upstream must hold its command.
- ovf flags are sticky until LOAD of that channel, CLEAR_ALL, or reset.
- Arithmetic is computed at WIDTH+1 bits; the MSB is the carry/borrow.
- Reset asserted mid-SWEEP aborts immediately to IDLE with everything zeroed.

Decomposition:
- Package step_accumulator_pkg:
  - cmd_op enum (OP_ADD, OP_SUB, OP_LOAD, OP_CLEAR_ALL).
  - FSM state enum (S_IDLE, S_SWEEP).
- One sub-module, sat_addsub: combinational WIDTH-bit add/sub with a SATURATE parameter, producing result and flag. It is instantiated once per channel on the tick path and once on the shared command path.

Test Plan (WIDTH=8, CHANNELS=4, STEP=3 unless noted):
1. Reset, then tick_en=4'b0001 for 5 cycles -> acc0 = 15, others 0, ovf = 0; assert reset mid-run -> all zero immediately, before the next edge.
2. LOAD ch1 = 254, then tick_en[1]=1 for 1 cycle -> SATURATE=0: acc1 = 1 and ovf[1] = 1. SATURATE=1: acc1 = 255 and ovf[1] = 1.
3. SUB ch2 by 5 from 0 -> SATURATE=0: 251 with ovf[2]=1. SATURATE=1: 0 with ovf[2]=1. Then LOAD ch2 = 7 -> ovf[2] = 0.
4. ADD ch0 by 10 with tick_en[0]=1 and tick_en[3]=1 in the same cycle -> acc0 += 10 only (tick dropped), acc3 += 3.
5. All channels nonzero, CLEAR_ALL -> busy=1 and cmd_ready=0 for exactly 4 cycles; channels zero in order 0..3 on successive cycles; ticks frozen throughout; a held ADD is accepted on the first IDLE cycle.
6. CHANNELS=1, WIDTH=4, STEP=15 -> ticks follow 15, 14(ovf), 13, ... (SATURATE=0); cmd_chan=1 is ignored.
